// File: rtl/ray_pkg.sv
// Shared types and default sizes for the ray-trace vector datapath.
package ray_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int VEC_LANES  = 3;
   localparam int TRI_VERTS  = 3;

   typedef logic signed [DATA_WIDTH-1:0] vec_t [VEC_LANES];

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   // A single-vector group still needs a 1-bit index port.
   function automatic int idx_width(input int group_size);
      return (group_size > 1) ? $clog2(group_size) : 1;
   endfunction

endpackage

// File: rtl/vec_skid_buf.sv
// Two-entry in-order vector buffer; r_head is always the oldest entry.
module vec_skid_buf
#(
   parameter int WIDTH = 96
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 i_clear,
   input  logic                 i_push,
   input  logic [WIDTH-1:0]     i_push_data,
   input  logic                 i_pop,
   output logic                 o_valid,
   output logic [WIDTH-1:0]     o_head,
   output ray_pkg::occ_e        o_occ
);
   import ray_pkg::*;

   occ_e             r_occ;
   occ_e             w_occ_nxt;
   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_tail;
   logic [WIDTH-1:0] w_head_nxt;
   logic [WIDTH-1:0] w_tail_nxt;

   // Next occupancy and entry contents from push/pop; clear wins over both.
   always_comb begin
      w_occ_nxt  = r_occ;
      w_head_nxt = r_head;
      w_tail_nxt = r_tail;
      if (i_clear) begin
         w_occ_nxt = OCC_EMPTY;
      end else begin
         case (r_occ)
            OCC_EMPTY: begin
               if (i_push) begin
                  w_head_nxt = i_push_data;
                  w_occ_nxt  = OCC_ONE;
               end else begin
                  w_occ_nxt  = OCC_EMPTY;
               end
            end
            OCC_ONE: begin
               if (i_push && i_pop) begin
                  w_head_nxt = i_push_data;
                  w_occ_nxt  = OCC_ONE;
               end else if (i_push) begin
                  w_tail_nxt = i_push_data;
                  w_occ_nxt  = OCC_TWO;
               end else if (i_pop) begin
                  w_occ_nxt  = OCC_EMPTY;
               end else begin
                  w_occ_nxt  = OCC_ONE;
               end
            end
            OCC_TWO: begin
               if (i_pop) begin
                  w_head_nxt = r_tail;
                  w_occ_nxt  = OCC_ONE;
               end else begin
                  w_occ_nxt  = OCC_TWO;
               end
            end
            default: begin
               w_occ_nxt = OCC_EMPTY;
            end
         endcase
      end
   end

   // Buffer state registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_occ  <= OCC_EMPTY;
         r_head <= {WIDTH{1'b0}};
         r_tail <= {WIDTH{1'b0}};
      end else begin
         r_occ  <= w_occ_nxt;
         r_head <= w_head_nxt;
         r_tail <= w_tail_nxt;
      end
   end

   assign o_valid = (r_occ != OCC_EMPTY);
   assign o_head  = r_head;
   assign o_occ   = r_occ;

endmodule

// File: rtl/ray_vec_unpacker.sv
// Pops vectors from a FWFT FIFO into a registered valid/ready stream,
// tagging group position and counting accepted transfers.
module ray_vec_unpacker
#(
   parameter int DATA_WIDTH = ray_pkg::DATA_WIDTH,
   parameter int ARRAY_SIZE = ray_pkg::VEC_LANES,
   parameter int GROUP_SIZE = ray_pkg::TRI_VERTS,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                                           clock,
   input  logic                                           reset,
   input  logic                                           clear,
   input  logic                                           in_empty,
   input  logic signed [DATA_WIDTH-1:0]                   in_data [ARRAY_SIZE],
   output logic                                           in_rd_en,
   output logic                                           out_valid,
   input  logic                                           out_ready,
   output logic signed [DATA_WIDTH-1:0]                   out_data [ARRAY_SIZE],
   output logic                                           out_last,
   output logic [((GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1)-1:0] out_index,
   output logic [CNT_WIDTH-1:0]                           out_count
);
   import ray_pkg::*;

   localparam int                   VEC_W     = DATA_WIDTH * ARRAY_SIZE;
   localparam int                   IDX_WIDTH = idx_width(GROUP_SIZE);
   localparam logic [IDX_WIDTH-1:0] GRP_LAST  = IDX_WIDTH'(GROUP_SIZE - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

   logic [VEC_W-1:0]     w_in_flat;
   logic [VEC_W-1:0]     w_head_flat;
   logic                 w_pop;
   logic                 w_xfer;
   logic                 w_valid;
   occ_e                 w_occ;
   logic [IDX_WIDTH-1:0] r_grp;
   logic [CNT_WIDTH-1:0] r_count;

   for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
      assign w_in_flat[g*DATA_WIDTH +: DATA_WIDTH] = in_data[g];
      assign out_data[g] = w_head_flat[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Pop only from registered occupancy, so out_ready never reaches in_rd_en.
   assign w_pop  = reset & ~in_empty & (w_occ != OCC_TWO) & ~clear;
   assign w_xfer = w_valid & out_ready;

   vec_skid_buf #(
      .WIDTH       (VEC_W)
   ) u_buf (
      .clock       (clock),
      .reset       (reset),
      .i_clear     (clear),
      .i_push      (w_pop),
      .i_push_data (w_in_flat),
      .i_pop       (w_xfer),
      .o_valid     (w_valid),
      .o_head      (w_head_flat),
      .o_occ       (w_occ)
   );

   // Position of the current head within its group.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_grp <= {IDX_WIDTH{1'b0}};
      end else if (clear) begin
         r_grp <= {IDX_WIDTH{1'b0}};
      end else if (w_xfer) begin
         r_grp <= (r_grp == GRP_LAST) ? {IDX_WIDTH{1'b0}} : r_grp + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r_grp <= r_grp;
      end
   end

   // Saturating count of accepted transfers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_count <= {CNT_WIDTH{1'b0}};
      end else if (clear) begin
         r_count <= {CNT_WIDTH{1'b0}};
      end else if (w_xfer && (r_count != CNT_MAX)) begin
         r_count <= r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r_count <= r_count;
      end
   end

   assign in_rd_en  = w_pop;
   assign out_valid = w_valid;
   assign out_last  = w_valid & (r_grp == GRP_LAST);
   assign out_index = r_grp;
   assign out_count = r_count;

endmodule

// File: tb/tb_ray_vec_unpacker.sv
// Directed and randomized bench; a FIFO queue feeds two DUT variants and a
// queue-based model of in-flight vectors predicts every output.
module tb_ray_vec_unpacker;

   localparam int VW = 96;

   logic clock     = 1'b0;
   logic reset     = 1'b0;
   logic clear     = 1'b0;
   logic in_empty  = 1'b1;
   logic out_ready = 1'b0;
   logic signed [31:0] in_data [3];

   logic               rd_a, valid_a, last_a;
   logic signed [31:0] data_a [3];
   logic [1:0]         idx_a;
   logic [31:0]        cnt_a;
   logic               rd_b, valid_b, last_b;
   logic signed [31:0] data_b [3];
   logic [0:0]         idx_b;
   logic [3:0]         cnt_b;
   logic [VW-1:0]      flat_a, flat_b;

   logic [VW-1:0] fifo [$];
   logic [VW-1:0] mq [$];
   longint        n_xfer = 0;
   int            n_pops = 0;
   int            n_checks = 0;
   int            n_pass = 0;

   always #5 clock = ~clock;

   assign flat_a = {data_a[2], data_a[1], data_a[0]};
   assign flat_b = {data_b[2], data_b[1], data_b[0]};

   ray_vec_unpacker dut_a (
      .clock(clock), .reset(reset), .clear(clear), .in_empty(in_empty),
      .in_data(in_data), .in_rd_en(rd_a), .out_valid(valid_a),
      .out_ready(out_ready), .out_data(data_a), .out_last(last_a),
      .out_index(idx_a), .out_count(cnt_a)
   );

   ray_vec_unpacker #(.GROUP_SIZE(1), .CNT_WIDTH(4)) dut_b (
      .clock(clock), .reset(reset), .clear(clear), .in_empty(in_empty),
      .in_data(in_data), .in_rd_en(rd_b), .out_valid(valid_b),
      .out_ready(out_ready), .out_data(data_b), .out_last(last_b),
      .out_index(idx_b), .out_count(cnt_b)
   );

   function automatic logic [VW-1:0] pk(input logic signed [31:0] l0, input logic signed [31:0] l1,
                                        input logic signed [31:0] l2);
      return {l2, l1, l0};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_outputs();
      logic   ev;
      longint grp;
      ev  = (mq.size() != 0);
      grp = n_xfer % 3;
      check("valid_a", valid_a, ev);
      check("valid_b", valid_b, ev);
      if (ev) begin
         check("data_a", flat_a, mq[0]);
         check("data_b", flat_b, mq[0]);
      end
      check("index_a", idx_a, grp);
      check("last_a", last_a, ev && (grp == 2));
      check("index_b", idx_b, 0);
      check("last_b", last_b, ev);
      check("count_a", cnt_a, n_xfer);
      check("count_b", cnt_b, (n_xfer > 15) ? 15 : n_xfer);
   endtask

   // One clock: drive at negedge, check at +1, update model at posedge.
   task automatic cycle(input logic clr, input logic rdy);
      logic [VW-1:0] head;
      logic          exp_rd, xfer, dut_rd;
      clear     = clr;
      out_ready = rdy;
      in_empty  = (fifo.size() == 0);
      head      = in_empty ? {$urandom, $urandom, $urandom} : fifo[0];
      for (int i = 0; i < 3; i++) in_data[i] = head[i*32 +: 32];
      #1;
      check_outputs();
      exp_rd = !in_empty && (mq.size() < 2) && !clr;
      check("rd_en_a", rd_a, exp_rd);
      check("rd_en_b", rd_b, exp_rd);
      dut_rd = rd_a;
      xfer   = (mq.size() != 0) && rdy;
      @(posedge clock);
      if (dut_rd) begin
         void'(fifo.pop_front());
         n_pops = n_pops + 1;
      end
      if (xfer) begin
         void'(mq.pop_front());
         n_xfer = n_xfer + 1;
      end
      if (exp_rd) mq.push_back(head);
      if (clr) begin
         mq.delete();
         n_xfer = 0;
      end
      @(negedge clock);
   endtask

   task automatic model_reset();
      fifo.delete();
      mq.delete();
      n_xfer = 0;
   endtask

   initial begin
      logic [VW-1:0] v0;
      int            p0;
      for (int i = 0; i < 3; i++) in_data[i] = 32'sd0;

      // Reset state with a non-empty FIFO present.
      @(negedge clock);
      for (int k = 0; k < 6; k++) fifo.push_back(pk(3*k+1, 3*k+2, 3*k+3));
      in_empty = 1'b0;
      for (int i = 0; i < 3; i++) in_data[i] = fifo[0][i*32 +: 32];
      #1;
      check("rst_rd_en", rd_a, 1'b0);
      check("rst_valid", valid_a, 1'b0);
      check("rst_data", flat_a, 96'd0);
      check("rst_count", cnt_a, 32'd0);
      check("rst_last", last_a, 1'b0);
      check("rst_index", idx_a, 2'd0);
      @(negedge clock);
      reset = 1'b1;

      // Streaming six vectors with out_ready high.
      p0 = n_pops;
      for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1);
      check("t1_pops", n_pops - p0, 6);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      check("t1_count", cnt_a, 32'd6);

      // Backpressure: only two pops, head held, then in-order drain.
      v0 = pk(-32'sd100, 32'sd7, 32'sd8);
      fifo.push_back(v0);
      for (int k = 1; k < 4; k++) fifo.push_back(pk(100*k, 100*k+1, -100*k));
      p0 = n_pops;
      for (int k = 0; k < 12; k++) cycle(1'b0, 1'b0);
      check("t2_pops", n_pops - p0, 2);
      check("t2_hold", flat_a, v0);
      for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1);
      check("t2_count", cnt_a, 32'd10);

      // Simultaneous pop and transfer with extreme lane values.
      fifo.push_back(pk(-32'sd5, 32'sd0, 32'sd2147483647));
      cycle(1'b0, 1'b0);
      for (int k = 0; k < 5; k++) fifo.push_back(pk(-32'sd5 - k, k, 32'sd2147483647 - k));
      p0 = n_pops;
      for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1);
      check("t3_pops", n_pops - p0, 5);
      cycle(1'b0, 1'b1);
      check("t3_count", cnt_a, 32'd16);

      // Clear with two entries buffered and group position 1.
      cycle(1'b1, 1'b0);
      fifo.push_back(pk(1, 1, 1));
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      check("t4_grp1", idx_a, 2'd1);
      for (int k = 0; k < 3; k++) fifo.push_back(pk(50+k, 60+k, 70+k));
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      check("t4_valid", valid_a, 1'b0);
      check("t4_count", cnt_a, 32'd0);
      check("t4_index", idx_a, 2'd0);
      p0 = n_pops;
      cycle(1'b1, 1'b1);
      check("t4_clr_nopop", n_pops - p0, 0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1);

      // Asynchronous reset between edges mid-burst.
      for (int k = 0; k < 6; k++) fifo.push_back(pk(900+k, -900-k, k));
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1);
      #3;
      reset = 1'b0;
      #1;
      check("t5_valid", valid_a, 1'b0);
      check("t5_rd_en", rd_a, 1'b0);
      check("t5_count", cnt_a, 32'd0);
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) fifo.push_back(pk(-k, -2*k, -3*k));
      for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1);

      // Saturation of the 4-bit counter; every vector is last with group size 1.
      cycle(1'b1, 1'b0);
      for (int k = 0; k < 20; k++) fifo.push_back(pk(k, k+1, k+2));
      for (int k = 0; k < 22; k++) cycle(1'b0, 1'b1);
      check("t6_count_b", cnt_b, 4'd15);
      check("t6_count_a", cnt_a, 32'd20);

      // Randomized traffic with occasional clears.
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 2) == 0) fifo.push_back({$urandom, $urandom, $urandom});
         if ($urandom_range(0, 3) == 0) fifo.push_back({$urandom, $urandom, $urandom});
         cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
      end
      for (int k = 0; k < 40; k++) cycle(1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ray_vec_unpacker.md
Name: ray_vec_unpacker

Overview:
- Read-side consumer of the 3-lane vector FIFO array (fifo_array) in the ray-trace datapath.
- Pops one vector per cycle from the first-word-fall-through FIFO interface and re-presents it as a fully registered valid/ready stream to the downstream intersection stage.
- Tags every GROUP_SIZE-th vector as the last of a group (e.g. 3 vertices = 1 triangle) and keeps a transfer count.
- No combinational path exists from out_ready to in_rd_en.

Parameters:
- DATA_WIDTH, 32, width of each signed lane (matches FIFO_DATA_WIDTH).
- ARRAY_SIZE, 3, number of lanes per vector.
- GROUP_SIZE, 3, vectors per group; legal range is 1 or more.
- CNT_WIDTH, 32, width of out_count.

Ports:
- clock  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush: drops buffered vectors and zeroes the counters.
- in_empty  in  1  FIFO empty flag; when low, in_data is the head vector.
- in_data  in  signed [DATA_WIDTH-1:0] x ARRAY_SIZE  FIFO head vector.
- in_rd_en  out  1  pop strobe to the FIFO; consumes the head in the same cycle.
- out_valid  out  1  out_data, out_last and out_index are valid.
- out_ready  in  1  downstream accepts when out_valid and out_ready are both high.
- out_data  out  signed [DATA_WIDTH-1:0] x ARRAY_SIZE  vector to downstream.
- out_last  out  1  marks the final vector of a group.
- out_index  out  $clog2(GROUP_SIZE) (minimum 1)  position of out_data within its group.
- out_count  out  CNT_WIDTH  total accepted output transfers; saturates.

Behaviour:
- Reset (reset low, asynchronous):
  - occupancy = 0, out_valid = 0, in_rd_en = 0.
  - group counter = 0, out_count = 0, out_last = 0, out_index = 0.
  - out_data = 0 (buffer storage is cleared too).
- Internal 2-entry buffer, occupancy state ∈ {EMPTY, ONE, TWO}; entries are kept in arrival order.
- Pop rule: in_rd_en = !in_empty && (occupancy != TWO) && !clear.
  - This depends only on registered state and in_empty.
  - The vector on in_data is captured on the same edge that in_rd_en is high.
- Output: out_valid = (occupancy != EMPTY), and out_data is the oldest entry.
  - A transfer is out_valid && out_ready.
- Occupancy next state = occupancy + pop − transfer.
  - EMPTY: pop goes to ONE.
  - ONE: pop with no transfer goes to TWO. Pop with transfer stays ONE, and the new word becomes the head after the edge. Transfer alone goes to EMPTY.
  - TWO: no pop is possible. Transfer goes to ONE and the second entry becomes the head.
- Latency: a vector popped at edge t is on out_valid/out_data after edge t (one cycle).
- Throughput: one vector per cycle while out_ready is held high and the FIFO is non-empty.
- Stall: out_data, out_last and out_index are held stable while out_valid && !out_ready.
- Group counter grp (0 .. GROUP_SIZE-1):
  - Increments on every transfer and wraps to 0 after GROUP_SIZE-1.
  - out_index = grp.
  - out_last = out_valid && (grp == GROUP_SIZE-1).
  - With GROUP_SIZE = 1, out_last = out_valid.
- out_count increments on every transfer and holds at all-ones (no wrap).
- clear (high on an edge):
  - occupancy goes to EMPTY, grp = 0, out_count = 0.
  - in_rd_en is forced low, so no FIFO word is lost during clear.
  - A transfer in the clear cycle still counts as taken by downstream, but the counters end at 0.
- in_empty high with occupancy ONE and a transfer: goes to EMPTY and out_valid drops on the next cycle (no bubble-hiding is required).
- Reset asserted mid-stream: buffered vectors are discarded. The FIFO shares the reset, so both sides restart empty.
- Lane arithmetic: none. Lanes pass through bit-exact, sign preserved.

Decomposition:
- Shared package ray_pkg:
  - Typedef vec_t, an array of ARRAY_SIZE signed DATA_WIDTH words.
  - Occupancy enum occ_e {OCC_EMPTY, OCC_ONE, OCC_TWO}.
  - Default constants DATA_WIDTH = 32, VEC_LANES = 3, TRI_VERTS = 3.
- One sub-module, vec_skid_buf: the 2-entry buffer and occupancy FSM with a push/pop interface.
- The top level adds the pop rule, group counter, out_count and clear.

Test Plan:
1. Reset then streaming: release reset; FIFO holds 6 vectors (1,2,3) … (16,17,18); out_ready = 1.
   - in_rd_en is high on 6 consecutive cycles.
   - Outputs appear one cycle later, back-to-back.
   - out_index = 0,1,2,0,1,2 and out_last is high on the 3rd and 6th vectors.
   - out_count = 6.
2. Backpressure: out_ready = 0 with 4 vectors queued.
   - Exactly 2 pops occur, then in_rd_en stays low (occupancy TWO).
   - out_data holds vector 0 unchanged for 10 cycles.
   - Raise out_ready: vectors 0..3 are delivered in order, with none dropped or duplicated.
3. Simultaneous pop and transfer: occupancy ONE, in_empty = 0, out_ready = 1.
   - Occupancy stays ONE and the head advances every cycle.
   - Lane values (−5, 0, 2147483647) pass through bit-exact.
4. clear while occupancy TWO and grp = 1.
   - Next cycle: out_valid = 0, out_count = 0, out_index = 0.
   - in_rd_en is low during the clear cycle.
   - The following FIFO vector is delivered with out_index = 0.
5. Async reset mid-burst: pull reset low between edges.
   - out_valid, in_rd_en and out_count go to 0 immediately, without waiting for a clock edge.
   - After release, the stream resumes from the fresh FIFO contents.
6. Saturation: CNT_WIDTH = 4, 20 transfers.
   - out_count reaches 15 and holds.
   - GROUP_SIZE = 1 variant: out_last is high on every valid vector.
